// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames the windowed sample stream into N-sample blocks
// for the FFT core, issues start/unload strobes and labels each output bin.
// It also flags dropped samples, core protocol violations and a stalled core.
//
// Ports:
//   clk, reset         slow-domain clock, async active-high reset
//   in_valid           windowed sample valid
//   fft_done, fft_dv   core transform-complete pulse, core output-data valid
//   out_ready          consumer can accept a full frame of bins
//   clr_err            synchronous clear of sticky flags and drop_count
//   fft_start          one-cycle start strobe to the core
//   fft_unload         one-cycle unload strobe to the core
//   in_index           index of the most recently accepted input sample
//   out_valid          bin valid (qualified fft_dv), out_index / out_last label it
//   busy               high whenever the sequencer is not idle
//   drop_err, timeout_err, proto_err   sticky error flags
//   frame_count        completed frames (wraps), drop_count dropped samples (saturates)
module fft_frame_sequencer #(
    parameter int unsigned N       = 128,
    parameter int unsigned IDX_W   = 7,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             fft_done,
    input  logic             fft_dv,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             fft_start,
    output logic             fft_unload,
    output logic [IDX_W-1:0] in_index,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             drop_err,
    output logic             timeout_err,
    output logic             proto_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        WAIT_RDY,
        UNLOAD
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sample_cnt;
    logic [IDX_W-1:0] bin_cnt;
    logic [WD_W-1:0]  wdog;

    logic drop_evt_c;
    logic proto_evt_c;

    // Samples arriving while the core owns the frame are lost.
    assign drop_evt_c = in_valid &&
                        ((state == COMPUTE) || (state == WAIT_RDY) || (state == UNLOAD));

    // Core handshakes outside the phase that expects them.
    assign proto_evt_c = (fft_dv && (state != UNLOAD)) ||
                         (fft_done && (state != COMPUTE));

    // Sequencer FSM with registered strobes, labels, flags and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bin_cnt     <= '0;
            wdog        <= '0;
            fft_start   <= 1'b0;
            fft_unload  <= 1'b0;
            in_index    <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            drop_err    <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            fft_start  <= 1'b0;
            fft_unload <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;

            // Clear first so that a same-cycle setting event below wins.
            if (clr_err) begin
                drop_err    <= 1'b0;
                timeout_err <= 1'b0;
                proto_err   <= 1'b0;
            end

            if (drop_evt_c) begin
                drop_err <= 1'b1;
                if (clr_err) begin
                    drop_count <= CNT_W'(1);
                end else if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
            end else if (clr_err) begin
                drop_count <= '0;
            end

            if (proto_evt_c) begin
                proto_err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        fft_start  <= 1'b1;
                        busy       <= 1'b1;
                        in_index   <= '0;
                        sample_cnt <= IDX_W'(1);
                        state      <= LOAD;
                    end
                end

                LOAD: begin
                    // Gaps simply stall; no watchdog while loading.
                    if (in_valid) begin
                        in_index <= sample_cnt;
                        if (sample_cnt == IDX_W'(N - 1)) begin
                            sample_cnt <= '0;
                            wdog       <= '0;
                            state      <= COMPUTE;
                        end else begin
                            sample_cnt <= sample_cnt + IDX_W'(1);
                        end
                    end
                end

                COMPUTE: begin
                    if (fft_done) begin
                        wdog <= '0;
                        if (out_ready) begin
                            fft_unload <= 1'b1;
                            bin_cnt    <= '0;
                            state      <= UNLOAD;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        // Stalled core: abandon the frame without unloading.
                        wdog        <= '0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end

                WAIT_RDY: begin
                    if (out_ready) begin
                        fft_unload <= 1'b1;
                        bin_cnt    <= '0;
                        state      <= UNLOAD;
                    end
                end

                UNLOAD: begin
                    if (fft_dv) begin
                        out_valid <= 1'b1;
                        out_index <= bin_cnt;
                        if (bin_cnt == IDX_W'(N - 1)) begin
                            out_last    <= 1'b1;
                            bin_cnt     <= '0;
                            frame_count <= frame_count + CNT_W'(1);
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            bin_cnt <= bin_cnt + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: full frames, gapped loading, drops,
// ready back-pressure, watchdog timeout, mid-frame reset and protocol errors.
module tb_fft_frame_sequencer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       fft_done;
    logic       fft_dv;
    logic       out_ready;
    logic       clr_err;
    logic       fft_start;
    logic       fft_unload;
    logic [6:0] in_index;
    logic       out_valid;
    logic [6:0] out_index;
    logic       out_last;
    logic       busy;
    logic       drop_err;
    logic       timeout_err;
    logic       proto_err;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    // Running totals gathered by the monitor.
    int n_start  = 0;
    int n_unload = 0;
    int n_ov     = 0;
    int n_last   = 0;
    int n_badidx = 0;
    logic [6:0] exp_bin = 7'd0;

    int s_start;
    int s_unload;
    int s_ov;
    int s_last;

    fft_frame_sequencer #(
        .N       (128),
        .IDX_W   (7),
        .TIMEOUT (4096),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .fft_done    (fft_done),
        .fft_dv      (fft_dv),
        .out_ready   (out_ready),
        .clr_err     (clr_err),
        .fft_start   (fft_start),
        .fft_unload  (fft_unload),
        .in_index    (in_index),
        .out_valid   (out_valid),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .drop_err    (drop_err),
        .timeout_err (timeout_err),
        .proto_err   (proto_err),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counting and bin-label checking on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_bin = 7'd0;
        end else begin
            if (fft_start)  n_start++;
            if (fft_unload) n_unload++;
            if (out_last)   n_last++;
            if (out_valid) begin
                n_ov++;
                if (out_index !== exp_bin) n_badidx++;
                if (out_last !== (exp_bin == 7'd127)) n_badidx++;
                exp_bin = exp_bin + 7'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < 128; i++) begin
            in_valid = 1'b1;
            tick();
            chk("load_in_index", 32'(in_index), 32'(i));
            if (i == 0) begin
                chk("load_start", 32'(fft_start), 1);
                chk("load_busy", 32'(busy), 1);
            end else if (i == 1) begin
                chk("load_start_width", 32'(fft_start), 0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic unload_frame(input int fc_exp);
        for (int i = 0; i < 128; i++) begin
            fft_dv = 1'b1;
            tick();
            chk("unl_out_valid", 32'(out_valid), 1);
            chk("unl_out_index", 32'(out_index), 32'(i));
            chk("unl_out_last", 32'(out_last), (i == 127) ? 1 : 0);
        end
        fft_dv = 1'b0;
        chk("unl_busy_low", 32'(busy), 0);
        chk("unl_frame_count", 32'(frame_count), 32'(fc_exp));
        tick();
        chk("unl_valid_drop", 32'(out_valid), 0);
        chk("unl_last_drop", 32'(out_last), 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        fft_done  = 1'b0;
        fft_dv    = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        repeat (3) tick();

        // Reset state.
        chk("rst_outputs", 32'({fft_start, fft_unload, out_valid, out_last, busy,
                                drop_err, timeout_err, proto_err}), 0);
        chk("rst_indices", 32'({in_index, out_index}), 0);
        chk("rst_counts", {frame_count, drop_count}, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Full frame, done 300 cycles after loading, consumer ready.
        s_start = n_start; s_unload = n_unload; s_ov = n_ov; s_last = n_last;
        load_frame();
        repeat (299) tick();
        chk("t1_no_early_unload", 32'(n_unload - s_unload), 0);
        fft_done  = 1'b1;
        out_ready = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("t1_unload", 32'(fft_unload), 1);
        tick();
        chk("t1_unload_width", 32'(fft_unload), 0);
        unload_frame(1);
        chk("t1_start_pulses", 32'(n_start - s_start), 1);
        chk("t1_unload_pulses", 32'(n_unload - s_unload), 1);
        chk("t1_bins", 32'(n_ov - s_ov), 128);
        chk("t1_last_count", 32'(n_last - s_last), 1);
        chk("t1_bin_labels", 32'(n_badidx), 0);
        chk("t1_flags", 32'({drop_err, timeout_err, proto_err}), 0);

        // Alternating valid: 128 accepted samples over 256 cycles.
        for (int i = 0; i < 256; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            chk("t2_in_index", 32'(in_index), 32'(i / 2));
        end
        in_valid = 1'b0;
        chk("t2_drop_count", 32'(drop_count), 0);
        chk("t2_drop_err", 32'(drop_err), 0);
        chk("t2_busy", 32'(busy), 1);

        // Three samples during COMPUTE are dropped, then cleared.
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t3_drop_err", 32'(drop_err), 1);
        chk("t3_drop_count", 32'(drop_count), 3);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_clr_drop_err", 32'(drop_err), 0);
        chk("t3_clr_drop_count", 32'(drop_count), 0);

        // Done with the consumer not ready: unload waits for out_ready.
        s_unload = n_unload;
        out_ready = 1'b0;
        fft_done  = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("t4_no_unload_done", 32'(fft_unload), 0);
        repeat (50) tick();
        chk("t4_no_unload_wait", 32'(n_unload - s_unload), 0);
        chk("t4_busy_wait", 32'(busy), 1);
        out_ready = 1'b1;
        tick();
        chk("t4_unload", 32'(fft_unload), 1);
        tick();
        unload_frame(2);
        chk("t4_proto", 32'(proto_err), 0);

        // Core never finishes: watchdog fires on cycle 4096 of COMPUTE.
        s_unload = n_unload;
        load_frame();
        repeat (4095) tick();
        chk("t5_no_timeout_yet", 32'(timeout_err), 0);
        chk("t5_busy_before", 32'(busy), 1);
        tick();
        chk("t5_timeout", 32'(timeout_err), 1);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_frame_count", 32'(frame_count), 2);
        chk("t5_no_unload", 32'(n_unload - s_unload), 0);

        // Next frame starts cleanly; reset lands at sample 60.
        in_valid = 1'b1;
        tick();
        chk("t6_start", 32'(fft_start), 1);
        chk("t6_in_index0", 32'(in_index), 0);
        for (int i = 1; i < 60; i++) begin
            tick();
            chk("t6_in_index", 32'(in_index), 32'(i));
        end
        s_start = n_start; s_unload = n_unload;
        reset = 1'b1;
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_index", 32'(in_index), 0);
        chk("t6_async_flags", 32'({drop_err, timeout_err, proto_err}), 0);
        chk("t6_async_frames", 32'(frame_count), 0);
        repeat (3) tick();
        chk("t6_no_strobes", 32'((n_start - s_start) + (n_unload - s_unload)), 0);
        chk("t6_rst_outputs", 32'({fft_start, fft_unload, out_valid, out_last, busy}), 0);
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();

        load_frame();
        repeat (9) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("t6_unload", 32'(fft_unload), 1);
        tick();
        unload_frame(1);

        // Stray dv in IDLE: no output beat, protocol flag set.
        s_ov = n_ov;
        fft_dv = 1'b1;
        tick();
        fft_dv = 1'b0;
        chk("t7_stray_valid", 32'(out_valid), 0);
        chk("t7_proto", 32'(proto_err), 1);
        tick();
        chk("t7_no_beat", 32'(n_ov - s_ov), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t7_proto_clr", 32'(proto_err), 0);

        // Stray done concurrent with clear: the flag wins, still idle.
        clr_err  = 1'b1;
        fft_done = 1'b1;
        tick();
        clr_err  = 1'b0;
        fft_done = 1'b0;
        chk("t8_proto_wins", 32'(proto_err), 1);
        chk("t8_idle", 32'(busy), 0);
        chk("t8_no_unload", 32'(fft_unload), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Single-clock controller that sequences the 128-point FFT core in the slow-clock domain of the Doppler chain. It frames the windowed sample stream into N-sample blocks, issues the FFT start and unload strobes, and tracks input, compute and output phases. It also flags dropped samples, lost frames and a stalled core, and labels each output bin for the spectrogram consumer.

## Interface
- N, 128, FFT frame length in samples/bins (power of two)
- IDX_W, 7, index width, log2(N)
- TIMEOUT, 4096, max cycles in COMPUTE waiting for done before abort
- CNT_W, 16, width of frame and drop counters
- clk  in  1  slow-domain clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  windowed sample valid (hamming window output valid)
- fft_done  in  1  core done pulse, transform complete
- fft_dv  in  1  core output-data valid
- out_ready  in  1  downstream consumer able to accept a full frame of bins
- clr_err  in  1  synchronous clear of sticky error flags
- fft_start  out  1  one-cycle start strobe to core
- fft_unload  out  1  one-cycle unload strobe to core
- in_index  out  IDX_W  index of current accepted input sample
- out_valid  out  1  bin valid to consumer (qualified fft_dv)
- out_index  out  IDX_W  bin number of current output
- out_last  out  1  high with bin N-1
- busy  out  1  high in any state except IDLE
- drop_err  out  1  sticky: in_valid seen while not accepting
- timeout_err  out  1  sticky: COMPUTE exceeded TIMEOUT
- proto_err  out  1  sticky: fft_dv outside UNLOAD or fft_done outside COMPUTE
- frame_count  out  CNT_W  completed frames, wraps
- drop_count  out  CNT_W  dropped samples, saturates at all-ones

## Operation
- States: IDLE, LOAD, COMPUTE, WAIT_RDY, UNLOAD.
- IDLE: on in_valid, pulse fft_start same cycle (registered, visible next cycle), count sample 0, go LOAD; in_index=0.
- LOAD: each in_valid increments sample counter; in_index follows counter. Gaps (in_valid=0) stall, no timeout. On the in_valid that accepts sample N-1, go COMPUTE and reset counter.
- COMPUTE: in_valid -> drop_err=1, drop_count+1. Watchdog counts cycles. fft_done with out_ready=1 -> pulse fft_unload, go UNLOAD. fft_done with out_ready=0 -> WAIT_RDY. Watchdog reaching TIMEOUT -> timeout_err=1, go IDLE, no unload, frame_count unchanged.
- WAIT_RDY: in_valid dropped and counted as in COMPUTE. out_ready=1 -> pulse fft_unload, go UNLOAD.
- UNLOAD: each fft_dv -> out_valid=1 with out_index=bin counter, then counter increments. out_last on bin N-1; after that beat, frame_count+1 and go IDLE. in_valid here is dropped and counted.
- fft_dv in any state but UNLOAD: out_valid stays 0, proto_err=1. fft_done outside COMPUTE: ignored, proto_err=1.
- clr_err clears drop_err, timeout_err, proto_err and drop_count. A flag-setting event in the same cycle wins; the flag stays 1.
- Counters: sample and bin counters are IDX_W bits and return to 0 at state exit; frame_count wraps modulo 2^CNT_W; drop_count saturates.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0. Asynchronous assertion mid-frame aborts immediately with no strobes. Exit from reset is synchronous to clk.
- fft_start is asserted the cycle after the first in_valid in IDLE, for exactly 1 cycle. In the same cycle the top-level one-cycle data delay presents sample 0 to the core.
- fft_unload is asserted the cycle after fft_done (or after out_ready rises in WAIT_RDY), for exactly 1 cycle.
- out_valid, out_index and out_last are registered: 1 cycle after the corresponding fft_dv.
- Minimum frame period is N LOAD cycles + core latency + 1 unload cycle + N dv cycles + 1 cycle return to IDLE. A new frame can start the cycle after UNLOAD exits.
- busy asserts the cycle after the first in_valid and deasserts the cycle after bin N-1.

## Test plan
- Continuous in_valid for 128 cycles, done 300 cycles later, out_ready=1, 128 dv beats -> exactly one start pulse and one unload pulse; out_index 0..127; out_last on bin 127 only; frame_count=1; all error flags 0.
- in_valid pattern 1-0-1-0 for 256 cycles -> state goes to COMPUTE only after the 128th accepted sample; in_index increments only on valid; drop_count=0.
- Three in_valid beats while in COMPUTE -> drop_err=1, drop_count=3; then clr_err -> both 0.
- fft_done with out_ready=0 for 50 cycles, then out_ready=1 -> no unload during the wait; unload pulse the cycle after out_ready rises; frame completes normally.
- No fft_done, TIMEOUT=4096 -> timeout_err=1 at cycle 4096 of COMPUTE; state returns to IDLE; frame_count unchanged; the next frame starts cleanly.
- reset asserted at sample 60 of LOAD, then a full frame -> all outputs 0 during reset; the next frame's in_index starts at 0; stray fft_dv in IDLE -> proto_err=1 and out_valid stays 0.
